// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the pipeline and pipe_stall_ctrl.
// Perf counter signals exist only when PIPE_STALL_CTRL_PERF_EN is defined.
interface pipe_stall_ctrl_if #(
  parameter int unsigned STAGES = 6,
  parameter int unsigned PC_W   = 32
);
  logic [STAGES-1:0] stallreq;
  logic              flush_req;
  logic [PC_W-1:0]   flush_pc;
  logic [STAGES-1:0] stall;
  logic              flush;
  logic [PC_W-1:0]   new_pc;
  logic              busy;
  logic              stall_timeout;
`ifdef PIPE_STALL_CTRL_PERF_EN
  logic [31:0]       stall_cycles;
  logic [31:0]       flush_count;
`endif

  modport master (
    output stallreq, flush_req, flush_pc,
`ifdef PIPE_STALL_CTRL_PERF_EN
    input  stall_cycles, flush_count,
`endif
    input  stall, flush, new_pc, busy, stall_timeout
  );

  modport slave (
    input  stallreq, flush_req, flush_pc,
`ifdef PIPE_STALL_CTRL_PERF_EN
    output stall_cycles, flush_count,
`endif
    output stall, flush, new_pc, busy, stall_timeout
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: thermometer stall vector, multi-cycle flush FSM, stall watchdog.
// Optional perf counters are built when PIPE_STALL_CTRL_PERF_EN is defined.
module pipe_stall_ctrl #(
  parameter int unsigned STAGES       = 6,
  parameter int unsigned PC_W         = 32,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned TIMEOUT      = 1024
) (
  input logic              clk,
  input logic              rst,
  pipe_stall_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [STAGES-1:0] therm;
  logic [STAGES-1:0] stall_vec;
  logic              seen;
  logic              stall_any;

  // A request at stage k holds every earlier stage as well.
  always_comb begin
    therm = '0;
    seen  = 1'b0;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      seen     = seen | bus.stallreq[i];
      therm[i] = seen;
    end
    stall_vec = (rst || bus.flush_req || state_q == StFlush) ? '0 : therm;
  end

  assign bus.stall = stall_vec;
  assign stall_any = |stall_vec;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    case (state_q)
      StIdle: begin
        if (bus.flush_req) begin
          state_d = StFlush;
          cnt_d   = CNT_LOAD;
          pc_d    = bus.flush_pc;
        end
      end
      StFlush: begin
        if (bus.flush_req) begin
          cnt_d = CNT_LOAD;
          pc_d  = bus.flush_pc;
        end else if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.flush  = (state_q == StFlush);
  assign bus.busy   = (state_q == StFlush);
  assign bus.new_pc = pc_q;

  if (TIMEOUT == 0) begin : g_no_wd
    assign bus.stall_timeout = 1'b0;
  end else begin : g_wd
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            to_q;

    always_comb begin
      wd_d = '0;
      if (stall_any) wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wd_q <= '0;
        to_q <= 1'b0;
      end else begin
        wd_q <= wd_d;
        if (wd_d == WD_MAX) to_q <= 1'b1;
      end
    end

    assign bus.stall_timeout = to_q;
  end

`ifdef PIPE_STALL_CTRL_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;

  // Every sampled flush_req is either an IDLE->FLUSH entry or a nested re-latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (stall_any)     stall_cycles_q <= stall_cycles_q + 32'd1;
      if (bus.flush_req) flush_count_q  <= flush_count_q + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_count  = flush_count_q;
`endif

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Parametrised pipeline control unit. Turns per-stage stall requests into a stall vector, sequences multi-cycle pipeline flushes with a redirect PC, and watches for stuck stalls. Sits beside the pipeline and drives the stall/flush inputs of every pipeline register (pc, if/id, id/ex, ex/mem, mem/wb). Replaces the fixed-width two-source stall controller.

## Interface
- STAGES, 6: number of pipeline stages. Bit 0 is the PC stage; higher index means a later stage.
- PC_W, 32: width of the redirect PC.
- FLUSH_CYCLES, 1: number of cycles `flush` is held per flush request. Must be ≥1.
- TIMEOUT, 1024: consecutive stalled cycles before `stall_timeout` sets. 0 disables the watchdog.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- stallreq  input  STAGES  per-stage stall request. Bit k is raised by stage k.
- flush_req  input  1  exception/redirect request, single-cycle pulse or level.
- flush_pc  input  PC_W  redirect target; valid when `flush_req`=1.
- stall  output  STAGES  per-stage hold. Combinational.
- flush  output  1  clears all pipeline registers. Registered.
- new_pc  output  PC_W  redirect PC; valid while `flush`=1. Registered.
- busy  output  1  high when the FSM is in FLUSH.
- stall_timeout  output  1  sticky watchdog flag.
- stall_cycles  output  32  perf counter; present only with the macro.
- flush_count  output  32  perf counter; present only with the macro.

## Operation
FSM states are IDLE and FLUSH. Reset enters IDLE.

Stall vector (IDLE, `flush_req`=0, `rst`=0):
- Let k be the highest set bit of `stallreq`.
- stall[i]=1 for i≤k; stall[i]=0 for i>k.
- No request set: stall=0.
- Example, STAGES=6: stallreq[2] gives 000111; stallreq[3] with or without [2] gives 001111.

Forced zero: `stall`=0 whenever any of the following holds:
- rst=1;
- flush_req=1, because flush has priority in the request cycle;
- state is FLUSH.

Flush sequencing:
- IDLE with flush_req=1 at an edge: go to FLUSH, latch new_pc←flush_pc, load the down-counter with FLUSH_CYCLES-1, register flush←1.
- In FLUSH: flush=1 and busy=1; stallreq is ignored.
- flush_req=1 while in FLUSH (nested exception): re-latch new_pc, reload the counter, stay in FLUSH.
- Counter at 0 with no flush_req: return to IDLE, flush←0.
- Otherwise decrement the counter.

Watchdog:
- Counts consecutive cycles with |stall=1. It clears on any cycle with stall=0.
- The counter saturates at TIMEOUT.
- When the count reaches TIMEOUT, stall_timeout←1. The flag holds until rst.
- TIMEOUT=0: the counter and flag are tied to 0.

Reset values: stall=0, flush=0, new_pc=0, busy=0, stall_timeout=0, all counters=0. A reset asserted mid-flush aborts the flush: flush drops on the next edge and the FSM goes to IDLE.

## Timing
- stall: 0-cycle latency from stallreq/flush_req. Purely combinational from inputs and state.
- flush/new_pc/busy: flush_req sampled at edge N gives flush=1 for cycles N+1 … N+FLUSH_CYCLES. The FSM is back in IDLE at edge N+FLUSH_CYCLES.
- Back-to-back: flush_req at N and again at N+1 gives flush held through N+1+FLUSH_CYCLES, with new_pc updated at N+2.
- stall during FLUSH is 0. The first cycle after flush ends follows the stallreq rules immediately.
- stall_timeout rises at the edge ending the TIMEOUT-th consecutive stalled cycle.

## Configuration
- PIPE_STALL_CTRL_PERF_EN defined:
  - stall_cycles increments every cycle with |stall=1.
  - flush_count increments on each IDLE→FLUSH transition and on each nested re-latch.
  - Both counters are 32-bit, wrap modulo 2^32, and are cleared by rst.
- Macro undefined: the counters and ports are absent and no counter logic is built.

## Test plan
- Priority: STAGES=6, stallreq=000100 gives stall=000111; then stallreq=001100 gives 001111; then 0 gives 000000, all in the same cycle.
- Flush mask: stallreq=001000 and flush_req=1 with flush_pc=0x80 at edge N.
  - Cycle N: stall=0.
  - Cycle N+1 (FLUSH_CYCLES=1): flush=1 and new_pc=0x80.
  - Cycle N+2: flush=0 and stall=001111.
- Multi-cycle/nested: FLUSH_CYCLES=3, flush_req pulses at N (pc 0x100) and N+2 (pc 0x200).
  - flush stays high N+1 … N+5.
  - new_pc=0x200 from N+3.
- Watchdog: TIMEOUT=4, stallreq[1] held 4 cycles, so stall_timeout sets at the 4th edge and stays 1 after stallreq drops. A 3-cycle stall, a gap, then a 3-cycle stall never sets it.
- Reset mid-flush: rst at FLUSH cycle 2 of 3 gives flush=0, busy=0, new_pc=0 next cycle, and stall=0 while rst=1.
- Perf (PIPE_STALL_CTRL_PERF_EN): 10 stalled cycles plus 2 flushes gives stall_cycles=10 and flush_count=2. Preload near 2^32-1 and confirm wrap to 0.
